// File: rtl/seven_seg_scroller_pkg.sv
// Shared types and constants for the seven-segment message scroller.
// Optional SEVEN_SEG_SCROLLER_BOUNCE_EN selects ping-pong scrolling.
package seven_seg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SHOW = 2'd2
  } state_e;

  typedef byte unsigned seven_seg_char_t;

  localparam seven_seg_char_t CHAR_BLANK = 8'h20;

endpackage

// File: rtl/seven_seg_scroller_if.sv
// Character stream into the scroller: valid/ready with a last flag.
// Master drives characters, slave (the scroller) returns ready.
interface seven_seg_scroller_if;
  import seven_seg_pkg::*;

  seven_seg_char_t char_in;
  logic            char_valid;
  logic            char_last;
  logic            char_ready;

  modport master (
    output char_in,
    output char_valid,
    output char_last,
    input  char_ready
  );

  modport slave (
    input  char_in,
    input  char_valid,
    input  char_last,
    output char_ready
  );

endinterface

// File: rtl/seven_seg_scroller_step_ticker.sv
// Free-running divider producing a one-cycle clock-enable tick.
// Counts only while enabled; synchronous clear restarts the period.
module step_ticker #(
  parameter int DIVISOR = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

  logic [CW-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == CW'(DIVISOR - 1));

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_tick ? '0 : r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/seven_seg_scroller.sv
// Buffers an ASCII message and drives a DIGITS-wide character window.
// Define SEVEN_SEG_SCROLLER_BOUNCE_EN for ping-pong instead of wrap scroll.
module seven_seg_scroller
  import seven_seg_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int MAX_LEN      = 16,
  parameter int STEP_DIVISOR = 25_000_000
) (
  input  logic                    clk,
  input  logic                    rst,
  seven_seg_scroller_if.slave     s_char,
  input  logic                    pause,
  output logic [DIGITS-1:0][7:0]  digits,
  output logic                    lap
);

  localparam int PW = $clog2(MAX_LEN + DIGITS + 1);

  typedef logic [PW-1:0] idx_t;

  state_e                  r_state;
  seven_seg_char_t         r_buf [MAX_LEN];
  idx_t                    r_len;
  idx_t                    r_pos;
  logic                    r_lap;
  logic [DIGITS-1:0][7:0]  r_digits;
`ifdef SEVEN_SEG_SCROLLER_BOUNCE_EN
  logic                    r_dir;
`endif

  logic                    w_wr;
  logic                    w_run;
  logic                    w_tick;
  logic                    w_scroll;
  logic                    w_flip;
  idx_t                    w_npos;
  idx_t                    w_widx;
  logic [DIGITS-1:0][7:0]  w_digits;

  assign s_char.char_ready = !rst;
  assign w_wr     = s_char.char_valid && s_char.char_ready;
  assign w_run    = (r_state == SHOW) && !pause;
  assign w_scroll = (r_state == SHOW) && (r_len > idx_t'(DIGITS));
  assign w_widx   = (r_state == LOAD) ? r_len : '0;

  step_ticker #(
    .DIVISOR (STEP_DIVISOR)
  ) u_ticker (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_run),
    .i_clr  (w_wr),
    .o_tick (w_tick)
  );

`ifdef SEVEN_SEG_SCROLLER_BOUNCE_EN
  always_comb begin
    w_npos = r_dir ? r_pos - idx_t'(1) : r_pos + idx_t'(1);
    w_flip = r_dir ? (w_npos == '0)
                   : (w_npos == r_len - idx_t'(DIGITS));
  end
`else
  always_comb begin
    w_flip = (r_pos == r_len + idx_t'(DIGITS) - idx_t'(1));
    w_npos = w_flip ? '0 : r_pos + idx_t'(1);
  end
`endif

  // A write always wins over a coincident step tick.
  always_ff @(posedge clk) begin
    r_lap <= 1'b0;
    if (rst) begin
      r_state <= IDLE;
      r_len   <= '0;
      r_pos   <= '0;
`ifdef SEVEN_SEG_SCROLLER_BOUNCE_EN
      r_dir   <= 1'b0;
`endif
    end else if (w_wr) begin
      r_pos   <= '0;
`ifdef SEVEN_SEG_SCROLLER_BOUNCE_EN
      r_dir   <= 1'b0;
`endif
      if (r_state != LOAD) begin
        r_len <= idx_t'(1);
      end else if (r_len < idx_t'(MAX_LEN)) begin
        r_len <= r_len + idx_t'(1);
      end
      r_state <= s_char.char_last ? SHOW : LOAD;
    end else if (w_tick && w_scroll) begin
      r_pos <= w_npos;
      r_lap <= w_flip;
`ifdef SEVEN_SEG_SCROLLER_BOUNCE_EN
      r_dir <= r_dir ^ w_flip;
`endif
    end
  end

  // Index MAX_LEN matches no slot, so overflow characters drop out.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      for (int j = 0; j < MAX_LEN; j++) begin
        if (w_widx == idx_t'(j)) begin
          r_buf[j] <= s_char.char_in;
        end
      end
    end
  end

  always_comb begin
    idx_t w_idx;
    w_digits = {DIGITS{CHAR_BLANK}};
    for (int k = 0; k < DIGITS; k++) begin
      w_idx = r_pos + idx_t'(k);
`ifndef SEVEN_SEG_SCROLLER_BOUNCE_EN
      if (w_idx >= r_len + idx_t'(DIGITS)) begin
        w_idx = w_idx - (r_len + idx_t'(DIGITS));
      end
`endif
      for (int j = 0; j < MAX_LEN; j++) begin
        if ((r_state == SHOW) && (w_idx < r_len) &&
            (w_idx == idx_t'(j))) begin
          w_digits[DIGITS-1-k] = r_buf[j];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_digits <= {DIGITS{CHAR_BLANK}};
    end else begin
      r_digits <= w_digits;
    end
  end

  assign digits = r_digits;
  assign lap    = r_lap;

endmodule

// File: tb/tb_seven_seg_scroller.sv
// Scoreboard bench: driver queues expected windows, monitor checks changes.
// Build with SEVEN_SEG_SCROLLER_BOUNCE_EN to check the ping-pong variant.
module tb_seven_seg_scroller;
  import seven_seg_pkg::*;

  localparam logic [31:0] BLANK = 32'h20202020;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        pause = 1'b0;
  logic [3:0][7:0] digits;
  logic        lap;

  seven_seg_scroller_if u_if ();

  seven_seg_scroller #(
    .DIGITS       (4),
    .MAX_LEN      (8),
    .STEP_DIVISOR (4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .s_char (u_if),
    .pause  (pause),
    .digits (digits),
    .lap    (lap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    int          cyc;
  } exp_t;

  exp_t        sb [$];
  int          cyc     = 0;
  int          checks  = 0;
  int          errors  = 0;
  int          lap_cnt = 0;
  bit          mon_en  = 1'b0;
  logic [31:0] prev_d  = BLANK;

`ifdef SEVEN_SEG_SCROLLER_BOUNCE_EN
  string hello_seq [11] = '{"HELL", "ELLO", "HELL", "ELLO", "HELL",
                            "ELLO", "HELL", "ELLO", "HELL", "ELLO",
                            "HELL"};
  string ovf_seq [13] = '{"ABCD", "BCDE", "CDEF", "DEFG", "EFGH",
                          "DEFG", "CDEF", "BCDE", "ABCD", "BCDE",
                          "CDEF", "DEFG", "EFGH"};
  int    hello_laps = 9;
  int    ovf_laps   = 3;
`else
  string hello_seq [11] = '{"HELL", "ELLO", "LLO ", "LO  ", "O   ",
                            "    ", "   H", "  HE", " HEL", "HELL",
                            "ELLO"};
  string ovf_seq [13] = '{"ABCD", "BCDE", "CDEF", "DEFG", "EFGH",
                          "FGH ", "GH  ", "H   ", "    ", "   A",
                          "  AB", " ABC", "ABCD"};
  int    hello_laps = 1;
  int    ovf_laps   = 1;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] pat(string s);
    return {s[0], s[1], s[2], s[3]};
  endfunction

  task automatic expect_d(string s, int c);
    exp_t e;
    e.d   = pat(s);
    e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic send(byte unsigned c, bit last);
    u_if.char_in    = c;
    u_if.char_valid = 1'b1;
    u_if.char_last  = last;
    @(negedge clk);
    u_if.char_valid = 1'b0;
    u_if.char_last  = 1'b0;
  endtask

  task automatic send_str(string s, bit last);
    for (int i = 0; i < s.len(); i++) begin
      send(s[i], last && (i == s.len() - 1));
    end
  endtask

  task automatic wait_to(int c);
    while (cyc < c) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (lap === 1'b1) lap_cnt++;
      if (digits !== prev_d) begin
        prev_d = digits;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change: got %h at cycle %0d, expected none",
                   digits, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (digits !== e.d || (e.cyc != 0 && cyc != e.cyc)) begin
            errors++;
            $display("FAIL digits_seq: got %h at cycle %0d, expected %h at cycle %0d",
                     digits, cyc, e.d, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    int n;
    int l0;
    u_if.char_in    = 8'h00;
    u_if.char_valid = 1'b0;
    u_if.char_last  = 1'b0;

    repeat (3) begin
      @(negedge clk);
      check("rst_digits", digits, BLANK);
      check("rst_ready", 32'(u_if.char_ready), 32'd0);
      check("rst_lap", 32'(lap), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(u_if.char_ready), 32'd1);
    mon_en = 1'b1;

    // static message
    send_str("HI", 1'b1);
    n  = cyc;
    l0 = lap_cnt;
    expect_d("HI  ", n + 1);
    repeat (100) @(negedge clk);
    check("static_lap", 32'(lap_cnt - l0), 32'd0);
    check("static_drain", 32'(sb.size()), 32'd0);

    // scroll, then pause mid-scroll
    send("H", 1'b0);
    expect_d("    ", cyc + 1);
    send_str("ELLO", 1'b1);
    n  = cyc;
    l0 = lap_cnt;
    for (int k = 0; k < 10; k++) expect_d(hello_seq[k], n + 1 + 4 * k);
    wait_to(n + 38);
    check("hello_laps", 32'(lap_cnt - l0), 32'(hello_laps));
    check("hello_drain", 32'(sb.size()), 32'd0);
    pause = 1'b1;
    repeat (20) @(negedge clk);
    pause = 1'b0;
    expect_d(hello_seq[10], n + 61);
    wait_to(n + 62);
    check("pause_drain", 32'(sb.size()), 32'd0);

    // abort with a one-character message
    send("O", 1'b1);
    n  = cyc;
    l0 = lap_cnt;
    expect_d("O   ", n + 1);
    repeat (10) @(negedge clk);
    check("abort_lap", 32'(lap_cnt - l0), 32'd0);
    check("abort_drain", 32'(sb.size()), 32'd0);

    // overflow: I and J dropped
    send("A", 1'b0);
    expect_d("    ", cyc + 1);
    send_str("BCDEFGHIJ", 1'b1);
    n  = cyc;
    l0 = lap_cnt;
    for (int k = 0; k < 13; k++) expect_d(ovf_seq[k], n + 1 + 4 * k);
    wait_to(n + 50);
    check("ovf_laps", 32'(lap_cnt - l0), 32'(ovf_laps));
    check("ovf_drain", 32'(sb.size()), 32'd0);

    // reset mid-load discards the partial message
    send("X", 1'b0);
    expect_d("    ", cyc + 1);
    send("Y", 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_digits", digits, BLANK);
    check("midrst_ready", 32'(u_if.char_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    send("Z", 1'b1);
    n = cyc;
    expect_d("Z   ", n + 1);
    repeat (5) @(negedge clk);
    check("midrst_drain", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seven_seg_scroller.md
# seven_seg_scroller

Upstream feeder for the seven-segment display controller. Accepts an ASCII message one character at a time over a valid/ready stream, buffers it, and produces the `DIGITS`-wide character array the display controller consumes. Messages that fit the display are shown statically and left-aligned; longer messages scroll leftward one position per step tick. Characters outside the controller's glyph set are passed through unchanged and display blank.

## Interface
- `DIGITS`, 4: display width in characters; must match the display controller.
- `MAX_LEN`, 16: message buffer depth in characters; must be ≥ `DIGITS` + 1.
- `STEP_DIVISOR`, 25_000_000: `clk` cycles per scroll step; must be ≥ 1.

- `clk` input 1: system clock.
- `rst` input 1: synchronous, active-high reset.
- `char_in` input 8: ASCII character.
- `char_valid` input 1: `char_in` is valid.
- `char_last` input 1: qualifies `char_in` as the final character of the message.
- `char_ready` output 1: character accepted when `char_valid && char_ready`.
- `pause` input 1: freezes the step counter and scroll position.
- `digits` output `DIGITS`×8, type `byte unsigned [DIGITS-1:0]`: registered characters, with `digits[DIGITS-1]` the leftmost.
- `lap` output 1: single-cycle pulse when the scroll position wraps.

## Operation
- States:
  - IDLE: reset state, no message.
  - LOAD: receiving a message.
  - SHOW: displaying a committed message.
- `char_ready` is 0 while `rst` is high and 1 otherwise; every valid character is accepted.
- Write handling:
  - A write in IDLE or SHOW starts a new message. The character goes to index 0, `len`=1, and the block enters LOAD. Any old message is discarded.
  - A write in LOAD stores the character at index `len` and increments `len`.
  - When `len` = `MAX_LEN`, further characters are accepted and dropped, and `len` saturates.
- A write with `char_last` commits the message (including that character, if it fits) and moves to SHOW with `pos`=0 and the step counter at 0. A single-character message is legal.
- In IDLE and LOAD, `digits` is all 0x20.
- Static display (SHOW, `len` ≤ `DIGITS`):
  - Leftmost digit shows `buf[0]`, the next shows `buf[1]`, and so on; unused digits show 0x20.
  - `pos` stays 0 and `lap` never fires.
- Scrolling display (SHOW, `len` > `DIGITS`):
  - Virtual sequence S = message followed by `DIGITS` blanks, with L = `len` + `DIGITS`.
  - The digit k positions from the left shows S[(`pos`+k) mod L].
  - On each step tick, `pos` increments. From L−1 it wraps to 0, and `lap` pulses in the wrap cycle.
- Step tick: fires when the step counter reaches `STEP_DIVISOR`−1, then the counter returns to 0. The counter runs only in SHOW with `pause`=0. It is a clock enable, not a derived clock.
- Simultaneous events:
  - A write and a step tick in the same cycle: the write wins, and `pos` is not advanced.
  - `pause` does not block writes.
- Reset: `len`=0, `pos`=0, step counter 0, state IDLE, `digits` all 0x20, `lap`=0.
- Reset mid-load or mid-scroll discards the message.

## Timing
- `digits` is registered from state/`pos`/buffer and lags them by 1 cycle.
- Commit latency:
  - Cycle N: the last character is accepted.
  - N+1: state is SHOW.
  - N+2: `digits` shows `pos` 0.
- Step latency: tick at cycle T; `pos` updates at T+1; `digits` updates at T+2. `lap` is asserted for exactly the one cycle in which `pos` holds 0 after a wrap.
- A new-message write in SHOW at cycle N gives blank `digits` at N+2.

## Configuration
- `SEVEN_SEG_SCROLLER_BOUNCE_EN` defined: ping-pong scroll for `len` > `DIGITS`.
  - No blank padding; leftmost digit shows `buf[pos]`.
  - `pos` runs 0 → `len`−`DIGITS`, then back down to 0, repeating.
  - `lap` pulses at each direction reversal, i.e. when `pos` reaches either end.
  - A reset or new message restarts the forward direction.
- Undefined: wrap scroll as described under Operation.

## Structure
- Package `seven_seg_pkg` holds:
  - the state enum (IDLE/LOAD/SHOW);
  - the `CHAR_BLANK` = 8'h20 constant;
  - the character type alias `seven_seg_char_t` (byte unsigned).
- Sub-module `step_ticker`: a parameterised counter with enable and synchronous clear, producing a one-cycle tick. The top level instantiates it with `STEP_DIVISOR`.

## Test plan
- Reset → `rst`=1 for 3 cycles: `digits` all 0x20, `char_ready`=0, `lap`=0. After release, `char_ready`=1.
- Static message → load "HI" (`char_last` on 'I'): 2 cycles later `digits` reads "HI␠␠" leftmost-first. No change and no `lap` over 100 cycles.
- Wrap scroll → `STEP_DIVISOR`=4, load "HELLO":
  - Sequence every 4 cycles: "HELL", "ELLO", "LLO␠", "LO␠␠", "O␠␠␠", "␠␠␠␠", "␠␠␠H", "␠␠HE", "␠HEL", then "HELL".
  - `lap` pulses once on return to "HELL".
- Overflow → `MAX_LEN`=8, write "ABCDEFGHIJ" with last on 'J': `len`=8. Scroll shows "ABCDEFGH" plus 4 blanks; 'I' and 'J' never appear.
- Pause/abort/reset:
  - `pause` held for 20 cycles mid-scroll freezes `digits`.
  - Writing "O" + last mid-scroll shows "O␠␠␠".
  - `rst` mid-load gives all blanks and IDLE.
- Bounce (macro defined) → "HELLO", `STEP_DIVISOR`=4: "HELL", "ELLO", "HELL", "ELLO", with `lap` on each reversal.
